// File: rtl/id_ex_if.sv
// -----------------------------------------------------------------------------
// id_ex_if : signal bundle around the ID/EX pipeline register.
//
// Groups everything except clk/reset/stall/flush:
//   id_*    decoded instruction fields coming out of ID
//   exm_*   EX/MEM write-back information used for forwarding
//   wb_*    MEM/WB write-back information used for forwarding
//   ex_*, alu_*, load_use_hazard   results presented to EX / hazard logic
//
// Modports:
//   master : upstream side (drives id_*/exm_*/wb_*, observes EX outputs)
//   slave  : the id_ex_stage register itself
// -----------------------------------------------------------------------------
interface id_ex_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    // ID stage fields
    logic          id_valid;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [1:0]    id_alu_op;
    logic [5:0]    id_funct;
    logic          id_alu_src;
    logic          id_reg_dst;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;

    // Downstream write-back information for forwarding
    logic          exm_reg_write;
    logic [RW-1:0] exm_rd;
    logic [DW-1:0] exm_result;
    logic          wb_reg_write;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_result;

    // EX stage outputs
    logic          ex_valid;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_control;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_write_reg;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          load_use_hazard;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
        input  ex_valid, alu_a, alu_b, alu_control, ex_store_data, ex_write_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_result,
        output ex_valid, alu_a, alu_b, alu_control, ex_store_data, ex_write_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register of the 5-stage MIPS core.
//
// Latches the decoded instruction from ID, produces ALU operands A/B and the
// 4-bit ALU control, the store data, the selected destination register and
// the registered MEM/WB controls, and flags load-use hazards back to the
// stall logic.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears every registered field
//   stall  hold current contents
//   flush  load a bubble (beats stall)
//   bus    id_ex_if.slave bundle (id_*, exm_*, wb_* in; ex_*/alu_* out)
//
// Build option:
//   ID_EX_FWD_EN  when defined, EX/MEM and MEM/WB results are forwarded onto
//                 the rs/rt operands (EX/MEM first, r0 never). When undefined
//                 the operands come straight from the latched register-file
//                 data and the exm_*/wb_* inputs are ignored.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [1:0]    alu_op;
        logic [5:0]    funct;
        logic          alu_src;
        logic          reg_dst;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } ex_regs_t;

    localparam int REG_W = $bits(ex_regs_t);

    ex_regs_t      regs_r;
    ex_regs_t      load_s;
    logic [DW-1:0] fwd_rs_s;
    logic [DW-1:0] fwd_rt_s;
    logic [DW-1:0] alu_b_s;
    logic          hazard_s;

    // ALU control decode from main-decoder ALUOp and R-type funct.
    function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] ctrl;
        case (op)
            2'b00: ctrl = 4'b0010;
            2'b01: ctrl = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: ctrl = 4'b0010;
                    6'b100010: ctrl = 4'b0110;
                    6'b100100: ctrl = 4'b0000;
                    6'b100101: ctrl = 4'b0001;
                    default:   ctrl = 4'b1111;
                endcase
            end
            default: ctrl = 4'b1111;
        endcase
        return ctrl;
    endfunction

    // Gather the ID fields into the register image to be captured.
    always_comb begin
        load_s            = ex_regs_t'({REG_W{1'b0}});
        load_s.valid      = bus.id_valid;
        load_s.rs_data    = bus.id_rs_data;
        load_s.rt_data    = bus.id_rt_data;
        load_s.imm        = bus.id_imm;
        load_s.rs         = bus.id_rs;
        load_s.rt         = bus.id_rt;
        load_s.rd         = bus.id_rd;
        load_s.alu_op     = bus.id_alu_op;
        load_s.funct      = bus.id_funct;
        load_s.alu_src    = bus.id_alu_src;
        load_s.reg_dst    = bus.id_reg_dst;
        load_s.reg_write  = bus.id_reg_write;
        load_s.mem_read   = bus.id_mem_read;
        load_s.mem_write  = bus.id_mem_write;
        load_s.mem_to_reg = bus.id_mem_to_reg;
    end

    // Pipeline register: reset and flush both produce an all-zero bubble.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            regs_r <= ex_regs_t'({REG_W{1'b0}});
        end else if (stall) begin
            regs_r <= regs_r;
        end else begin
            regs_r <= load_s;
        end
    end

`ifdef ID_EX_FWD_EN
    // Pick the newest in-flight value of a source register; r0 is hard-wired.
    function automatic logic [DW-1:0] fwd_pick(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] rf_data,
        input logic          exm_we,
        input logic [RW-1:0] exm_rd,
        input logic [DW-1:0] exm_res,
        input logic          wb_we,
        input logic [RW-1:0] wb_rd,
        input logic [DW-1:0] wb_res
    );
        logic [DW-1:0] val;
        if (exm_we && (exm_rd == idx) && (idx != {RW{1'b0}})) begin
            val = exm_res;
        end else if (wb_we && (wb_rd == idx) && (idx != {RW{1'b0}})) begin
            val = wb_res;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Operand bypass from EX/MEM and MEM/WB.
    always_comb begin
        fwd_rs_s = fwd_pick(regs_r.rs, regs_r.rs_data,
                            bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                            bus.wb_reg_write, bus.wb_rd, bus.wb_result);
        fwd_rt_s = fwd_pick(regs_r.rt, regs_r.rt_data,
                            bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                            bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    end
`else
    // No bypass: operands are the latched register-file data.
    always_comb begin
        fwd_rs_s = regs_r.rs_data;
        fwd_rt_s = regs_r.rt_data;
    end

    // Forwarding inputs and the latched rs index have no consumer in this build.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                            bus.wb_reg_write, bus.wb_rd, bus.wb_result, regs_r.rs};
`endif

    // Operand B: immediate for I-type/memory ops, otherwise rt.
    always_comb begin
        if (regs_r.alu_src) begin
            alu_b_s = regs_r.imm;
        end else begin
            alu_b_s = fwd_rt_s;
        end
    end

    // Load-use detection: a load in EX whose rt is read by the instruction in ID.
    // Bubbles carry valid=0 and mem_read=0, so they never raise it.
    always_comb begin
        if (regs_r.valid && regs_r.mem_read && (regs_r.rt != {RW{1'b0}}) && bus.id_valid &&
            ((regs_r.rt == bus.id_rs) || (regs_r.rt == bus.id_rt))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign bus.ex_valid        = regs_r.valid;
    assign bus.alu_a           = fwd_rs_s;
    assign bus.alu_b           = alu_b_s;
    assign bus.alu_control     = alu_decode(regs_r.alu_op, regs_r.funct);
    assign bus.ex_store_data   = fwd_rt_s;
    assign bus.ex_write_reg    = regs_r.reg_dst ? regs_r.rd : regs_r.rt;
    assign bus.ex_reg_write    = regs_r.reg_write;
    assign bus.ex_mem_read     = regs_r.mem_read;
    assign bus.ex_mem_write    = regs_r.mem_write;
    assign bus.ex_mem_to_reg   = regs_r.mem_to_reg;
    assign bus.load_use_hazard = hazard_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage : directed scenarios followed by random traffic, every output
// compared each cycle against a behavioural model of the ID/EX register.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic reset;
    logic stall;
    logic flush;

    id_ex_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the instruction currently held for EX.
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } m_t;

    m_t m;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_alu(input logic [1:0] op, input logic [5:0] funct);
        logic [5:0] r_funct [4] = '{6'h20, 6'h22, 6'h24, 6'h25};
        logic [3:0] r_ctrl  [4] = '{4'h2, 4'h6, 4'h0, 4'h1};
        if (op == 2'd0) return 4'h2;
        if (op == 2'd1) return 4'h6;
        if (op == 2'd3) return 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (r_funct[i] == funct) return r_ctrl[i];
        end
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_operand(input logic [4:0] idx, input logic [31:0] rf);
        if (FWD && idx != 5'd0 && bus.exm_reg_write && bus.exm_rd == idx) return bus.exm_result;
        if (FWD && idx != 5'd0 && bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_result;
        return rf;
    endfunction

    task automatic model_update();
        if (reset || flush) begin
            m = m_t'(0);
        end else if (!stall) begin
            m.valid      = bus.id_valid;
            m.rs_data    = bus.id_rs_data;
            m.rt_data    = bus.id_rt_data;
            m.imm        = bus.id_imm;
            m.rs         = bus.id_rs;
            m.rt         = bus.id_rt;
            m.rd         = bus.id_rd;
            m.alu_op     = bus.id_alu_op;
            m.funct      = bus.id_funct;
            m.alu_src    = bus.id_alu_src;
            m.reg_dst    = bus.id_reg_dst;
            m.reg_write  = bus.id_reg_write;
            m.mem_read   = bus.id_mem_read;
            m.mem_write  = bus.id_mem_write;
            m.mem_to_reg = bus.id_mem_to_reg;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ea;
        logic [31:0] es;
        logic [31:0] eb;
        logic        eh;
        ea = exp_operand(m.rs, m.rs_data);
        es = exp_operand(m.rt, m.rt_data);
        eb = m.alu_src ? m.imm : es;
        eh = m.valid && m.mem_read && (m.rt != 5'd0) && bus.id_valid &&
             ((m.rt == bus.id_rs) || (m.rt == bus.id_rt));
        check_value("ex_valid",      64'(bus.ex_valid),        64'(m.valid));
        check_value("alu_a",         64'(bus.alu_a),           64'(ea));
        check_value("alu_b",         64'(bus.alu_b),           64'(eb));
        check_value("alu_control",   64'(bus.alu_control),     64'(exp_alu(m.alu_op, m.funct)));
        check_value("ex_store_data", 64'(bus.ex_store_data),   64'(es));
        check_value("ex_write_reg",  64'(bus.ex_write_reg),    64'(m.reg_dst ? m.rd : m.rt));
        check_value("ex_reg_write",  64'(bus.ex_reg_write),    64'(m.reg_write));
        check_value("ex_mem_read",   64'(bus.ex_mem_read),     64'(m.mem_read));
        check_value("ex_mem_write",  64'(bus.ex_mem_write),    64'(m.mem_write));
        check_value("ex_mem_to_reg", 64'(bus.ex_mem_to_reg),   64'(m.mem_to_reg));
        check_value("load_use",      64'(bus.load_use_hazard), 64'(eh));
    endtask

    // Sample between edges, then let one rising edge go by.
    task automatic sample();
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rs_d, input logic [31:0] rt_d,
                          input logic [31:0] imm, input logic [1:0] op, input logic [5:0] fn,
                          input logic src, input logic dst, input logic rw, input logic mr,
                          input logic mw, input logic mtr);
        bus.id_valid = v;       bus.id_rs = rs;          bus.id_rt = rt;
        bus.id_rd = rd;         bus.id_rs_data = rs_d;   bus.id_rt_data = rt_d;
        bus.id_imm = imm;       bus.id_alu_op = op;      bus.id_funct = fn;
        bus.id_alu_src = src;   bus.id_reg_dst = dst;    bus.id_reg_write = rw;
        bus.id_mem_read = mr;   bus.id_mem_write = mw;   bus.id_mem_to_reg = mtr;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
        bus.exm_reg_write = ew; bus.exm_rd = erd; bus.exm_result = eres;
        bus.wb_reg_write  = ww; bus.wb_rd  = wrd; bus.wb_result  = wres;
    endtask

    task automatic rand_id();
        logic [5:0] fn_pool [5];
        fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'($urandom)};
        set_id(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
               2'($urandom), fn_pool[$urandom_range(0, 4)], 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic rand_fwd();
        set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; stall = 1'b0; flush = 1'b0;
        m = m_t'(0);
        set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h5, 32'h7, 32'h10, 2'b10, 6'b100000,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        @(negedge clk);
        tick();
        tick();

        // Reset state, and load an R-type add.
        reset = 1'b0;
        set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h5, 32'h7, 32'h0, 2'b10, 6'b100000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        check_value("rst_valid",   64'(bus.ex_valid),     64'(1'b0));
        check_value("rst_alu_a",   64'(bus.alu_a),        64'(32'h0));
        check_value("rst_alu_b",   64'(bus.alu_b),        64'(32'h0));
        check_value("rst_alu_ctl", 64'(bus.alu_control),  64'(4'b0010));
        check_value("rst_reg_wr",  64'(bus.ex_reg_write), 64'(1'b0));
        tick();

        bus.id_funct = 6'b100101;
        sample();
        check_value("add_alu_a",  64'(bus.alu_a),        64'(32'h5));
        check_value("add_alu_b",  64'(bus.alu_b),        64'(32'h7));
        check_value("add_ctl",    64'(bus.alu_control),  64'(4'b0010));
        check_value("add_wreg",   64'(bus.ex_write_reg), 64'(5'd9));
        tick();

        bus.id_funct = 6'b101010;
        sample();
        check_value("or_ctl", 64'(bus.alu_control), 64'(4'b0001));
        tick();

        // Forwarding priority on rs=3 (latched data 0x33).
        set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h33, 32'h7, 32'h0, 2'b10, 6'b100000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sample();
        check_value("slt_ctl", 64'(bus.alu_control), 64'(4'b1111));
        tick();

        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        sample();
        check_value("fwd_exm", 64'(bus.alu_a), 64'(FWD ? 32'h11 : 32'h33));
        bus.exm_reg_write = 1'b0;
        sample();
        check_value("fwd_wb", 64'(bus.alu_a), 64'(FWD ? 32'h22 : 32'h33));
        set_id(1'b1, 5'd0, 5'd4, 5'd9, 32'h0, 32'h7, 32'h0, 2'b10, 6'b100000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        tick();

        sample();
        check_value("fwd_r0", 64'(bus.alu_a), 64'(32'h0));

        // Load-use detection: lw with rt=8 in EX.
        set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 2'b00, 6'd0,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        set_id(1'b1, 5'd8, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 2'b10, 6'h20,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sample();
        check_value("lu_rs", 64'(bus.load_use_hazard), 64'(1'b1));
        bus.id_rt = 5'd0;
        sample();
        check_value("lu_rs_rt0", 64'(bus.load_use_hazard), 64'(1'b1));
        bus.id_rs = 5'd5; bus.id_rt = 5'd6;
        sample();
        check_value("lu_nomatch", 64'(bus.load_use_hazard), 64'(1'b0));
        bus.id_rs = 5'd8; bus.id_valid = 1'b0;
        sample();
        check_value("lu_id_bubble", 64'(bus.load_use_hazard), 64'(1'b0));
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 2'b00, 6'd0,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();

        // Load with rt=0 in EX never hazards; then latch a sub into EX.
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 32'h55, 32'h66, 32'h0, 2'b01, 6'd0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        sample();
        check_value("lu_rt0", 64'(bus.load_use_hazard), 64'(1'b0));
        tick();

        // Stall holds the sub for three cycles despite changing ID inputs.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            sample();
            check_value("stall_valid", 64'(bus.ex_valid),     64'(1'b1));
            check_value("stall_wreg",  64'(bus.ex_write_reg), 64'(5'd7));
            check_value("stall_alu_a", 64'(bus.alu_a),        64'(32'h55));
            check_value("stall_ctl",   64'(bus.alu_control),  64'(4'b0110));
            tick();
        end
        flush = 1'b1;
        sample();
        tick();
        flush = 1'b0; stall = 1'b0;
        sample();
        check_value("flush_valid", 64'(bus.ex_valid),      64'(1'b0));
        check_value("flush_rw",    64'(bus.ex_reg_write),  64'(1'b0));
        check_value("flush_mr",    64'(bus.ex_mem_read),   64'(1'b0));
        check_value("flush_mw",    64'(bus.ex_mem_write),  64'(1'b0));
        check_value("flush_mtr",   64'(bus.ex_mem_to_reg), 64'(1'b0));

        // sw: B from immediate, store data from MEM/WB.
        set_id(1'b1, 5'd1, 5'd5, 5'd0, 32'h200, 32'h1234, 32'hFFFF_FFFC, 2'b00, 6'd0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hABCD);
        rand_id();
        sample();
        check_value("sw_alu_b",  64'(bus.alu_b),         64'(32'hFFFF_FFFC));
        check_value("sw_store",  64'(bus.ex_store_data), 64'(FWD ? 32'hABCD : 32'h1234));
        check_value("sw_mem_wr", 64'(bus.ex_mem_write),  64'(1'b1));
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            rand_fwd();
            reset = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 4) == 0);
            sample();
            tick();
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        sample();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the 5-stage MIPS core. It sits directly upstream of the EX-stage ALU.
- Latches decoded instruction fields from ID.
- Drives the ALU's A, B and 4-bit ALU control.
- Resolves EX/MEM and MEM/WB data forwarding.
- Flags load-use hazards back to the hazard/stall logic.

Parameters:
- DW, 32, datapath width (register data, immediate, ALU operands)
- RW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current contents (ID/EX not loaded)
- flush  in  1  load a bubble on next edge
- id_valid  in  1  ID holds a real instruction
- id_rs_data  in  DW  register-file read port 1
- id_rt_data  in  DW  register-file read port 2
- id_imm  in  DW  sign-extended immediate
- id_rs  in  RW  source register index 1
- id_rt  in  RW  source register index 2
- id_rd  in  RW  destination register index
- id_alu_op  in  2  main-decoder ALUOp
- id_funct  in  6  R-type funct field
- id_alu_src  in  1  1 = B from immediate
- id_reg_dst  in  1  1 = write rd, 0 = write rt
- id_reg_write  in  1  control
- id_mem_read  in  1  control
- id_mem_write  in  1  control
- id_mem_to_reg  in  1  control
- exm_reg_write  in  1  EX/MEM stage writes a register
- exm_rd  in  RW  EX/MEM destination
- exm_result  in  DW  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB stage writes a register
- wb_rd  in  RW  MEM/WB destination
- wb_result  in  DW  MEM/WB write-back value
- ex_valid  out  1  registered valid
- alu_a  out  DW  ALU operand A
- alu_b  out  DW  ALU operand B
- alu_control  out  4  ALU function code
- ex_store_data  out  DW  forwarded rt value for stores
- ex_write_reg  out  RW  selected destination index
- ex_reg_write  out  1  registered control
- ex_mem_read  out  1  registered control
- ex_mem_write  out  1  registered control
- ex_mem_to_reg  out  1  registered control
- load_use_hazard  out  1  request stall of IF/ID

Behaviour:
- Register update on rising clk edge, priority reset > flush > stall > load.
- reset: all registered fields go to 0.
  - Resulting outputs: ex_valid=0, all ex_* controls=0, ex_write_reg=0, alu_a=0, alu_b=0, ex_store_data=0, alu_control=4'b0010, load_use_hazard=0.
  - Reset mid-stream discards the in-flight instruction.
- flush (including flush with stall): every registered field is cleared to 0, i.e. a bubble; flush beats stall.
- stall without flush: all registers hold their values. Outputs may still change through forwarding as EX/MEM and MEM/WB advance.
- load: all id_* fields are captured. Latency is 1 cycle, ID inputs to EX outputs.
- ex_write_reg = registered reg_dst ? rd : rt.
- Forwarding is combinational from registered rs/rt plus the exm_*/wb_* inputs. For each operand X in {rs, rt}:
  - If exm_reg_write and exm_rd==X and X!=0, use exm_result.
  - Else if wb_reg_write and wb_rd==X and X!=0, use wb_result.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - alu_a = forwarded rs.
  - ex_store_data = forwarded rt.
  - alu_b = registered alu_src ? registered imm : forwarded rt.
- ALU control is combinational from the registered alu_op/funct:
  - alu_op 00 -> 0010 (add)
  - alu_op 01 -> 0110 (sub)
  - alu_op 10, by funct:
    - 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - any other funct -> 1111 (ALU yields 0)
  - alu_op 11 -> 1111
- load_use_hazard (combinational) = ex_valid & ex_mem_read & ex_rt!=0 & id_valid & (ex_rt==id_rs | ex_rt==id_rt).
  - External logic asserts stall on IF/ID and flush here on the following edge.
- Bubble (valid=0) never asserts load_use_hazard. Its controls are 0, so downstream sees no writes.

Optional Feature:
ID_EX_FWD_EN
- Defined: forwarding muxes exist as described above.
- Undefined: forwarding logic is removed. exm_*/wb_* inputs are ignored. alu_a/ex_store_data are the registered register-file data, and alu_b uses registered rt data when alu_src=0. load_use_hazard is unchanged. Software/hazard logic must stall for all RAW hazards.

Test Plan:
1. Reset held 2 cycles with all id_* nonzero -> ex_valid=0, alu_a=0, alu_b=0, alu_control=0010, ex_reg_write=0.
2. Load R-type add: rs=3 (data 5), rt=4 (data 7), rd=9, alu_op=10, funct=100000, reg_dst=1 -> next cycle alu_a=5, alu_b=7, alu_control=0010, ex_write_reg=9. Repeat with funct=100101 -> alu_control=0001; funct=101010 -> 1111.
3. Forwarding (ID_EX_FWD_EN), rs=3:
   - exm_reg_write=1, exm_rd=3, exm_result=0x11 and wb_reg_write=1, wb_rd=3, wb_result=0x22 -> alu_a=0x11.
   - Drop exm_reg_write -> alu_a=0x22.
   - rs=0 with exm_rd=0 -> alu_a = register-file data (0).
4. Load-use: registered lw (mem_read=1, rt=8, valid=1) and id_rs=8, id_valid=1 -> load_use_hazard=1. Same with id_rt=0, id_rs=8 -> 1. ex_rt=0 -> 0.
5. stall=1 for 3 cycles with changing id_* inputs -> registered outputs unchanged. stall=1 and flush=1 together -> bubble loaded: ex_valid=0, all controls 0.
6. sw with alu_src=1, imm=0xFFFFFFFC, rt=5 forwarded from wb_result=0xABCD -> alu_b=0xFFFFFFFC, ex_store_data=0xABCD, ex_mem_write=1.
